// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - dmem port arbiter between processor M stage and VGA board reader
module dmem_arbiter #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  proc_req,
  input  logic                  proc_wren,
  input  logic [ADDR_WIDTH-1:0] proc_addr,
  input  logic [DATA_WIDTH-1:0] proc_data,
  output logic [DATA_WIDTH-1:0] proc_q,
  output logic                  proc_stall,
  input  logic                  vga_req,
  input  logic [ADDR_WIDTH-1:0] vga_addr,
  output logic                  vga_ack,
  output logic                  vga_valid,
  output logic [DATA_WIDTH-1:0] vga_q,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_data,
  output logic                  dmem_wren,
  input  logic [DATA_WIDTH-1:0] dmem_q
);

  // Limit held in the counter's own width so the compare is 8 bit on both sides.
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0]            starve_cnt_q, starve_cnt_d;
  logic                  iss_d1_q, iss_d1_d;
  logic                  vga_valid_q, vga_valid_d;
  logic [DATA_WIDTH-1:0] vga_q_q, vga_q_d;
  logic                  force_grant;
  logic                  vga_own;

  // Owner selection: processor first, VGA on idle cycles or when starved too long.
  always_comb begin
    force_grant = vga_req && (starve_cnt_q >= LIMIT);
    vga_own     = force_grant || (vga_req && !proc_req);
    proc_stall  = force_grant && proc_req;
    vga_ack     = vga_own;
    dmem_addr   = vga_own ? vga_addr : proc_addr;
    // Store data is don't-care while the VGA owns the port, so it is never muxed.
    dmem_data   = proc_data;
    dmem_wren   = !vga_own && proc_req && proc_wren;
    proc_q      = dmem_q;
    vga_valid   = vga_valid_q;
    vga_q       = vga_q_q;
  end

  // Next-state: starvation counter and the one-deep read-return pipeline.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!vga_req || vga_own) begin
      starve_cnt_d = 8'd0;
    end else if (starve_cnt_q != 8'hFF) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end
    // dmem_q carries the VGA word in the cycle after issue; capture it then.
    iss_d1_d    = vga_own;
    vga_valid_d = iss_d1_q;
    vga_q_d     = iss_d1_q ? dmem_q : vga_q_q;
  end

  // State registers; reset drops any read still in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt_q <= 8'd0;
      iss_d1_q     <= 1'b0;
      vga_valid_q  <= 1'b0;
      vga_q_q      <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      iss_d1_q     <= iss_d1_d;
      vga_valid_q  <= vga_valid_d;
      vga_q_q      <= vga_q_d;
    end
  end

endmodule
